// File: rtl/cpu.sv
// cpu: single-cycle accumulator/register processor running a fixed ROM program.
// Ports: clk, rst (sync, active-high) in; result (=R0), zero, carry flags out.
module cpu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [3:0]       pc;
    logic [WIDTH-1:0] regs [4];
    logic             halted;

    logic [11:0]      ins;
    logic [3:0]       op;
    logic [1:0]       rd;
    logic [1:0]       rs;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sumi;
    logic [WIDTH:0]   diff;

    logic             wen;
    logic             fen;
    logic             hlt;
    logic             cout;
    logic [WIDTH-1:0] wdata;

    // Program ROM; unused slots are HALT so the PC never wraps.
    always_comb begin
        ins = 12'hF00;
        case (pc)
            4'd0:    ins = 12'h145;
            4'd1:    ins = 12'h187;
            4'd2:    ins = 12'h360;
            4'd3:    ins = 12'h849;
            4'd4:    ins = 12'h1C2;
            4'd5:    ins = 12'h470;
            4'd6:    ins = 12'h210;
            default: ins = 12'hF00;
        endcase
    end

    assign op  = ins[11:8];
    assign rd  = ins[7:6];
    assign rs  = ins[5:4];
    assign imm = WIDTH'(ins[3:0]);
    assign a   = regs[rd];
    assign b   = regs[rs];

    // Widened by one bit so the MSB is the carry-out / borrow.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign sumi = {1'b0, a} + {1'b0, imm};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        wen   = 1'b0;
        fen   = 1'b0;
        hlt   = 1'b0;
        cout  = 1'b0;
        wdata = '0;
        case (op)
            OP_LDI: begin
                wen   = 1'b1;
                wdata = imm;
            end
            OP_MOV: begin
                wen   = 1'b1;
                wdata = b;
            end
            OP_ADD: begin
                wen   = 1'b1;
                fen   = 1'b1;
                wdata = sum[WIDTH-1:0];
                cout  = sum[WIDTH];
            end
            OP_SUB: begin
                wen   = 1'b1;
                fen   = 1'b1;
                wdata = diff[WIDTH-1:0];
                cout  = diff[WIDTH];
            end
            OP_AND: begin
                wen   = 1'b1;
                fen   = 1'b1;
                wdata = a & b;
            end
            OP_OR: begin
                wen   = 1'b1;
                fen   = 1'b1;
                wdata = a | b;
            end
            OP_XOR: begin
                wen   = 1'b1;
                fen   = 1'b1;
                wdata = a ^ b;
            end
            OP_ADDI: begin
                wen   = 1'b1;
                fen   = 1'b1;
                wdata = sumi[WIDTH-1:0];
                cout  = sumi[WIDTH];
            end
            OP_HALT: hlt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= '0;
            regs   <= '{default: '0};
            zero   <= 1'b0;
            carry  <= 1'b0;
            halted <= 1'b0;
        end else if (!halted) begin
            // HALT freezes the PC on itself.
            if (hlt) begin
                halted <= 1'b1;
            end else begin
                pc <= pc + 4'd1;
            end
            if (wen) begin
                regs[rd] <= wdata;
            end
            if (fen) begin
                zero  <= ~|wdata;
                carry <= cout;
            end
        end
    end

    assign result = regs[0];

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: table-driven and randomized-reset checks of cpu at WIDTH 4 and 8.
// Reference: instruction-level interpreter of the program with integer arithmetic.
module tb_cpu;

    logic       clk;
    logic       rst;
    logic [3:0] res4;
    logic       z4;
    logic       c4;
    logic [7:0] res8;
    logic       z8;
    logic       c8;

    int vectors;
    int miscompares;

    cpu #(4) u4 (
        .clk(clk),
        .rst(rst),
        .result(res4),
        .zero(z4),
        .carry(c4)
    );

    cpu #(.WIDTH(8)) u8 (
        .clk(clk),
        .rst(rst),
        .result(res8),
        .zero(z8),
        .carry(c8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program as {opcode, rd, rs, imm} rows.
    int p_op  [16];
    int p_rd  [16];
    int p_rs  [16];
    int p_imm [16];

    // Model state, index 0 = WIDTH 4, index 1 = WIDTH 8.
    int m_pc [2];
    int m_r  [2][4];
    int m_z  [2];
    int m_c  [2];
    int m_h  [2];

    typedef struct {
        logic rst;
        int   r1;
        int   res;
        int   z;
        int   c;
        int   pc;
    } vec_t;

    vec_t tbl [9];

    task automatic load_prog();
        for (int i = 0; i < 16; i++) begin
            p_op[i] = 15; p_rd[i] = 0; p_rs[i] = 0; p_imm[i] = 0;
        end
        p_op[0] = 1; p_rd[0] = 1; p_imm[0] = 5;
        p_op[1] = 1; p_rd[1] = 2; p_imm[1] = 7;
        p_op[2] = 3; p_rd[2] = 1; p_rs[2] = 2;
        p_op[3] = 8; p_rd[3] = 1; p_imm[3] = 9;
        p_op[4] = 1; p_rd[4] = 3; p_imm[4] = 2;
        p_op[5] = 4; p_rd[5] = 1; p_rs[5] = 3;
        p_op[6] = 2; p_rd[6] = 0; p_rs[6] = 1;
    endtask

    task automatic model_step(input int k, input logic r);
        int m, x, y, v, op;
        m = (k == 0) ? 16 : 256;
        if (r) begin
            m_pc[k] = 0; m_z[k] = 0; m_c[k] = 0; m_h[k] = 0;
            for (int i = 0; i < 4; i++) m_r[k][i] = 0;
        end else if (m_h[k] == 0) begin
            op = p_op[m_pc[k]];
            x = m_r[k][p_rd[m_pc[k]]];
            y = m_r[k][p_rs[m_pc[k]]];
            v = x;
            case (op)
                1: v = p_imm[m_pc[k]] % m;
                2: v = y;
                3: begin v = x + y; m_c[k] = int'(v >= m); v = v % m; end
                4: begin m_c[k] = int'(x < y); v = (x - y + m) % m; end
                5: begin v = x & y; m_c[k] = 0; end
                6: begin v = x | y; m_c[k] = 0; end
                7: begin v = x ^ y; m_c[k] = 0; end
                8: begin
                    v = x + p_imm[m_pc[k]];
                    m_c[k] = int'(v >= m);
                    v = v % m;
                end
                default: ;
            endcase
            if (op >= 3 && op <= 8) m_z[k] = int'(v == 0);
            if (op >= 1 && op <= 8) m_r[k][p_rd[m_pc[k]]] = v;
            if (op == 15) m_h[k] = 1;
            else m_pc[k] = (m_pc[k] + 1) % 16;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One rising edge with the given reset level; sample 1 time unit later.
    task automatic tick(input logic r);
        rst = r;
        @(posedge clk);
        #1;
        model_step(0, r);
        model_step(1, r);
    endtask

    task automatic check_final(input string tag);
        check({tag, " result4"}, int'(res4), 3);
        check({tag, " zero4"}, int'(z4), 0);
        check({tag, " carry4"}, int'(c4), 0);
        check({tag, " result8"}, int'(res8), 19);
        check({tag, " zero8"}, int'(z8), 0);
        check({tag, " carry8"}, int'(c8), 0);
        check({tag, " pc4"}, int'(u4.pc), 7);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        load_prog();

        // Two reset edges, then the seven executing edges.
        tbl[0] = '{1'b1, 0, 0, 0, 0, 0};
        tbl[1] = '{1'b1, 0, 0, 0, 0, 0};
        tbl[2] = '{1'b0, 5, 0, 0, 0, 1};
        tbl[3] = '{1'b0, 5, 0, 0, 0, 2};
        tbl[4] = '{1'b0, 12, 0, 0, 0, 3};
        tbl[5] = '{1'b0, 5, 0, 0, 1, 4};
        tbl[6] = '{1'b0, 5, 0, 0, 1, 5};
        tbl[7] = '{1'b0, 3, 0, 0, 0, 6};
        tbl[8] = '{1'b0, 3, 3, 0, 0, 7};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            tick(tbl[i].rst);
            check($sformatf("v%0d r1", i), int'(u4.regs[1]), tbl[i].r1);
            check($sformatf("v%0d result", i), int'(res4), tbl[i].res);
            check($sformatf("v%0d zero", i), int'(z4), tbl[i].z);
            check($sformatf("v%0d carry", i), int'(c4), tbl[i].c);
            check($sformatf("v%0d pc", i), int'(u4.pc), tbl[i].pc);
        end
        check("w8 r1 after 7", int'(u8.regs[1]), 19);
        check_final("edge7");

        // Stable through cycle 20 and 50 more cycles after halt.
        for (int i = 0; i < 63; i++) begin
            tick(1'b0);
            check_final($sformatf("hold%0d", i));
        end

        // Mid-program reset on the 4th edge, where ADDI would set carry.
        tick(1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0);
        check("pre-rst r1", int'(u4.regs[1]), 12);
        tick(1'b1);
        check("mid-rst result", int'(res4), 0);
        check("mid-rst carry", int'(c4), 0);
        check("mid-rst zero", int'(z4), 0);
        check("mid-rst r1", int'(u4.regs[1]), 0);
        check("mid-rst pc", int'(u4.pc), 0);
        for (int i = 0; i < 6; i++) tick(1'b0);
        check("rerun edge6 result", int'(res4), 0);
        tick(1'b0);
        check_final("rerun");

        // Random reset pulses against the interpreter.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0);
            check($sformatf("rnd%0d res4", i), int'(res4), m_r[0][0]);
            check($sformatf("rnd%0d z4", i), int'(z4), m_z[0]);
            check($sformatf("rnd%0d c4", i), int'(c4), m_c[0]);
            check($sformatf("rnd%0d pc4", i), int'(u4.pc), m_pc[0]);
            check($sformatf("rnd%0d res8", i), int'(res8), m_r[1][0]);
            check($sformatf("rnd%0d c8", i), int'(c8), m_c[1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
